// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the multiplexed 7-segment driver.
// Codes are active-high {g,f,e,d,c,b,a}; polarity is applied by the top.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_CODE_0     = 7'h3F;
    localparam logic [6:0] SEG_CODE_1     = 7'h06;
    localparam logic [6:0] SEG_CODE_2     = 7'h5B;
    localparam logic [6:0] SEG_CODE_3     = 7'h4F;
    localparam logic [6:0] SEG_CODE_4     = 7'h66;
    localparam logic [6:0] SEG_CODE_5     = 7'h6D;
    localparam logic [6:0] SEG_CODE_6     = 7'h7D;
    localparam logic [6:0] SEG_CODE_7     = 7'h07;
    localparam logic [6:0] SEG_CODE_8     = 7'h7F;
    localparam logic [6:0] SEG_CODE_9     = 7'h6F;
    localparam logic [6:0] SEG_CODE_DASH  = 7'h40;
    localparam logic [6:0] SEG_CODE_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; 10..15 show a dash.
// Ports: bcd_i (4-bit digit) -> seg_o (7-bit {g,f,e,d,c,b,a}).
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        unique case (bcd_i)
            4'd0:    seg_o = SEG_CODE_0;
            4'd1:    seg_o = SEG_CODE_1;
            4'd2:    seg_o = SEG_CODE_2;
            4'd3:    seg_o = SEG_CODE_3;
            4'd4:    seg_o = SEG_CODE_4;
            4'd5:    seg_o = SEG_CODE_5;
            4'd6:    seg_o = SEG_CODE_6;
            4'd7:    seg_o = SEG_CODE_7;
            4'd8:    seg_o = SEG_CODE_8;
            4'd9:    seg_o = SEG_CODE_9;
            default: seg_o = SEG_CODE_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver: shadow-captures BCD digits on LATCH and
// scans them one slot (SCAN_DIV clocks) at a time onto SEG/DP with one-hot DIG_SEL.
// Ports: CLK, RST (sync, active-high), EN, LATCH, BCD_IN, DP_IN ->
//        SEG, DP, DIG_SEL, FRAME_DONE (all registered).
// Option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 never).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    LATCH,
    input  logic [4*NUM_DIGITS-1:0] BCD_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   DIG_SEL,
    output logic                    FRAME_DONE
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   dps_q;
    logic [DW-1:0]           div_q, div_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    fd_q, fd_d;

    bcd_t       cur_bcd;
    logic       cur_dp;
    logic       cur_blank;
    logic [6:0] code;
    logic [6:0] lit;

    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_bcd = bcd_q[4*i +: 4];
                cur_dp  = dps_q[i];
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every more-significant digit are zero.
    logic [NUM_DIGITS:0] lz;

    always_comb begin
        lz             = '0;
        lz[NUM_DIGITS] = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lz[i] = lz[i+1] && (bcd_q[4*i +: 4] == 4'd0);
        end
        cur_blank = 1'b0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_blank = lz[i];
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .bcd_i (cur_bcd),
        .seg_o (code)
    );

    assign lit = cur_blank ? SEG_CODE_BLANK : code;

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        dig_d = DIG_OFF;
        fd_d  = 1'b0;
        if (EN) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                fd_d  = (idx_q == IDX_LAST);
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
            seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
            dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dig_d[i] = (idx_q == IW'(i)) ^ DIG_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bcd_q <= '0;
            dps_q <= '0;
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            dig_q <= DIG_OFF;
            fd_q  <= 1'b0;
        end else begin
            if (LATCH) begin
                bcd_q <= BCD_IN;
                dps_q <= DP_IN;
            end
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            dig_q <= dig_d;
            fd_q  <= fd_d;
        end
    end

    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign DIG_SEL    = dig_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (4 digits, 4 clocks/slot,
// active-low segments and digit selects).
module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        LATCH;
    logic [15:0] BCD_IN;
    logic [3:0]  DP_IN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  DIG_SEL;
    logic        FRAME_DONE;

    int n_chk = 0;
    int n_err = 0;

    logic [6:0] zseg;

    // Slot tables for BCD 1234 / DP 0100, active-low.
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] exp_dig [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .LATCH      (LATCH),
        .BCD_IN     (BCD_IN),
        .DP_IN      (DP_IN),
        .SEG        (SEG),
        .DP         (DP),
        .DIG_SEL    (DIG_SEL),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_seg"}, SEG, 7'h7F);
        chk({tag, "_dp"}, DP, 1'b1);
        chk({tag, "_dig"}, DIG_SEL, 4'hF);
        chk({tag, "_fd"}, FRAME_DONE, 1'b0);
    endtask

    initial begin
        zseg   = LZ ? 7'h7F : 7'h40;
        RST    = 1'b1;
        EN     = 1'b1;
        LATCH  = 1'b0;
        BCD_IN = '0;
        DP_IN  = '0;
        tick();
        tick();
        chk_off("rst");

        // Normal scan of 1234.
        RST    = 1'b0;
        LATCH  = 1'b1;
        BCD_IN = 16'h1234;
        DP_IN  = 4'b0100;
        for (int n = 1; n <= 32; n++) begin
            tick();
            LATCH = 1'b0;
            if (n == 1) begin
                chk("scan_old_seg", SEG, 7'h40);
                chk("scan_old_dig", DIG_SEL, 4'hE);
            end else begin
                chk("scan_seg", SEG, exp_seg[((n-1)/4)%4]);
                chk("scan_dig", DIG_SEL, exp_dig[((n-1)/4)%4]);
                chk("scan_dp", DP, exp_dp[((n-1)/4)%4]);
            end
            chk("scan_fd", FRAME_DONE, 32'((n % 16) == 0));
            chk("scan_1hot", $countones(~DIG_SEL), 1);
        end

        // Invalid BCD digit shows a dash.
        LATCH  = 1'b1;
        BCD_IN = 16'h00A0;
        DP_IN  = 4'b0000;
        for (int n = 33; n <= 42; n++) begin
            tick();
            LATCH = 1'b0;
            if (n == 34) begin
                chk("inv_d0_seg", SEG, 7'h40);
                chk("inv_d0_dig", DIG_SEL, 4'hE);
            end
            if (n == 38) begin
                chk("inv_d1_seg", SEG, 7'h3F);
                chk("inv_d1_dig", DIG_SEL, 4'hD);
            end
            if (n == 42) begin
                chk("inv_d2_seg", SEG, zseg);
                chk("inv_d2_dig", DIG_SEL, 4'hB);
            end
        end

        // Freeze mid digit 2, then resume.
        EN = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_off("frz");
        end
        EN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("res_fd", FRAME_DONE, 32'(k == 6));
            if (k <= 2) begin
                chk("res_dig", DIG_SEL, 4'hB);
            end else begin
                chk("res_dig", DIG_SEL, 4'h7);
                chk("res_seg", SEG, zseg);
            end
        end

        // LATCH on the same edge as a slot advance.
        for (int k = 1; k <= 13; k++) begin
            tick();
            LATCH = 1'b0;
            if (k == 3) begin
                LATCH  = 1'b1;
                BCD_IN = 16'h9876;
            end
            if (k == 4) begin
                chk("adv_old_seg", SEG, 7'h40);
                chk("adv_old_dig", DIG_SEL, 4'hE);
            end
            if (k == 5) begin
                chk("adv_new_seg", SEG, 7'h78);
                chk("adv_new_dig", DIG_SEL, 4'hD);
            end
            if (k == 13) begin
                chk("adv_d3_seg", SEG, 7'h10);
                chk("adv_d3_dig", DIG_SEL, 4'h7);
            end
        end

        // Reset during digit 3.
        RST = 1'b1;
        tick();
        chk_off("mrst");
        RST = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            LATCH = 1'b0;
            if (k == 1) begin
                chk("mrst_d0_seg", SEG, 7'h40);
                chk("mrst_d0_dig", DIG_SEL, 4'hE);
            end
            if (k == 4) chk("mrst_d0_end", DIG_SEL, 4'hE);
            if (k == 5) begin
                chk("mrst_d1_dig", DIG_SEL, 4'hD);
                LATCH  = 1'b1;
                BCD_IN = 16'h0050;
                DP_IN  = 4'b0010;
            end
            if (k == 7) begin
                chk("lz_d1_seg", SEG, 7'h12);
                chk("lz_d1_dp", DP, 1'b0);
            end
            if (k == 10) begin
                chk("lz_d2_seg", SEG, zseg);
                chk("lz_d2_dig", DIG_SEL, 4'hB);
                chk("lz_d2_dp", DP, 1'b1);
            end
            if (k == 14) begin
                chk("lz_d3_seg", SEG, zseg);
                chk("lz_d3_dig", DIG_SEL, 4'h7);
            end
            if (k == 18) begin
                chk("lz_d0_seg", SEG, 7'h40);
                chk("lz_d0_dig", DIG_SEL, 4'hE);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Multiplexed 7-segment display driver sitting directly downstream of the CNT10 decade-counter chain. It captures a packed vector of BCD digits (the DOUT values of cascaded counters) into a shadow register on a LATCH strobe, then time-multiplexes one digit at a time onto a shared segment bus with a one-hot digit select. Scan rate comes from an internal prescaler.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned (≥1)
SCAN_DIV, 50000, clock cycles per digit slot (≥1)
SEG_ACTIVE_LOW, 1, 1: SEG/DP lit when 0; 0: lit when 1
DIG_ACTIVE_LOW, 1, 1: DIG_SEL selected when 0; 0: selected when 1

Ports:
CLK  in  1  system clock, rising-edge
RST  in  1  synchronous, active-high reset
EN  in  1  scan enable; 0 freezes scan and blanks display
LATCH  in  1  capture strobe for BCD_IN/DP_IN (typically a counter COUT or a frame tick)
BCD_IN  in  4*NUM_DIGITS  packed digits; [3:0] = digit 0 = least significant
DP_IN  in  NUM_DIGITS  decimal-point request per digit
SEG  out  7  segments {g,f,e,d,c,b,a}, SEG[0]=a
DP  out  1  decimal point of the currently selected digit
DIG_SEL  out  NUM_DIGITS  one-hot digit enable
FRAME_DONE  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high; it wins over every other input.
- Reset values:
  - shadow digits = 0, shadow DP = 0, div_cnt = 0, idx = 0.
  - SEG and DP = unlit level; DIG_SEL = all deselected; FRAME_DONE = 0.
- Capture:
  - LATCH=1 at an edge loads shadow <= BCD_IN and DP_IN. LATCH is level-sampled, so holding it high reloads every cycle.
  - Latency: the edge after capture shows the new value on SEG/DP for the current idx.
- Prescaler:
  - While EN=1, div_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances by 1.
  - idx wraps NUM_DIGITS-1 -> 0. On that wrap edge FRAME_DONE=1 for exactly one cycle.
  - SCAN_DIV=1 advances idx every cycle.
  - div_cnt width is max(1, clog2(SCAN_DIV)); idx width is max(1, clog2(NUM_DIGITS)).
- Outputs:
  - SEG, DP and DIG_SEL are registered from the current idx and shadow, so there is one cycle of latency after any idx or shadow change.
  - Exactly one DIG_SEL bit is active while EN=1 and not in reset.
- EN=0:
  - div_cnt and idx hold.
  - Next edge: DIG_SEL all deselected, SEG/DP unlit, FRAME_DONE=0.
  - On EN returning to 1, scanning resumes at the held idx and div_cnt.
- Decode (active-high codes, inverted when SEG_ACTIVE_LOW=1):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Values 10–15 show a dash (40).
- Simultaneous LATCH and idx advance: both take effect. The new digit is decoded from the newly captured value on the following edge.
- Reset mid-scan: everything returns to reset values at that edge. The scan restarts at digit 0 with div_cnt=0 once RST=0.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: any digit i>0 whose value and all more-significant digit values are 0 has SEG unlit. Its DP still follows shadow DP, and DIG_SEL is still driven. Digit 0 is never blanked.
- Undefined: all digits are decoded normally, so zeros show as 3F.

Decomposition:
- Package seg7_pkg:
  - segment code constants SEG_CODE_0..SEG_CODE_9, SEG_CODE_DASH, SEG_CODE_BLANK (active-high);
  - bcd_t (4-bit) typedef.
- One natural combinational sub-module: bcd_to_seg7, mapping 4-bit BCD to 7-bit active-high code. Polarity inversion stays in seg7_scan_ctrl.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=4, both polarities active-low unless noted.)
- Reset: RST=1 for 2 cycles -> SEG=7'h7F, DP=1, DIG_SEL=4'hF, FRAME_DONE=0. Hold values while RST=1 with EN=1.
- Normal scan:
  - Stimulus: EN=1, LATCH pulse with BCD_IN=16'h1234, DP_IN=4'b0100.
  - Digit slots of 4 cycles each: DIG_SEL 1110/SEG=19, 1101/SEG=30, 1011/SEG=24 with DP=0, 0111/SEG=79.
  - FRAME_DONE: one-cycle pulse on the 3->0 wrap, every 16 cycles.
- Invalid BCD: BCD_IN=16'h00A0 -> digit 1 slot SEG=7'h3F (dash); digit 0 shows 40 (zero).
- Freeze: drop EN during digit 2 slot -> next cycle DIG_SEL=4'hF and SEG=7'h7F. Restoring EN resumes digit 2 with the remaining div_cnt count, and FRAME_DONE is not pulsed early.
- Boundaries:
  - LATCH on the same edge as a slot advance -> the new digit shows the new value one cycle later.
  - RST during digit 3 -> next slot is digit 0 with SEG showing 40 (zero).
- With SEG7_LEADING_ZERO_BLANK_EN defined, BCD_IN=16'h0050: digits 3,2 -> SEG=7'h7F; digit 1 -> 12 (five); digit 0 -> 40 (zero, never blanked).
